// File: rtl/jtag_tap_if.sv
// TAP controller <-> test environment / DR mux signal bundle.
// JTAG_TAP_STATE_OUT_EN adds the tap_state debug observation signal.
interface jtag_tap_if #(
    parameter int unsigned IR_WIDTH = 2
);
    logic                tms;
    logic                tdi;
    logic                dr_tdo;
    logic                shift_dr;
    logic                clk_dr;
    logic                update_dr;
    logic                capture_dr;
    logic [IR_WIDTH-1:0] sel;
    logic                tdo;
    logic                tdo_en;
`ifdef JTAG_TAP_STATE_OUT_EN
    logic [3:0]          tap_state;

    modport master (
        input  tms, tdi, dr_tdo,
        output shift_dr, clk_dr, update_dr, capture_dr, sel, tdo, tdo_en, tap_state
    );
    modport slave (
        output tms, tdi, dr_tdo,
        input  shift_dr, clk_dr, update_dr, capture_dr, sel, tdo, tdo_en, tap_state
    );
`else
    modport master (
        input  tms, tdi, dr_tdo,
        output shift_dr, clk_dr, update_dr, capture_dr, sel, tdo, tdo_en
    );
    modport slave (
        output tms, tdi, dr_tdo,
        input  shift_dr, clk_dr, update_dr, capture_dr, sel, tdo, tdo_en
    );
`endif
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP FSM, instruction register and tdo merge feeding the DR mux.
// Define JTAG_TAP_STATE_OUT_EN to expose the raw state register on tap.tap_state.
module jtag_tap_ctrl #(
    parameter int unsigned         IR_WIDTH   = 2,
    parameter logic [IR_WIDTH-1:0] IR_RESET   = IR_WIDTH'(2'b01),
    parameter logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01)
) (
    input  logic       clk,
    input  logic       rst,
    jtag_tap_if.master tap
);

    typedef enum logic [3:0] {
        TLR   = 4'hF,
        RTI   = 4'hC,
        SELDR = 4'h7,
        CAPDR = 4'h6,
        SHDR  = 4'h2,
        EX1DR = 4'h1,
        PSDR  = 4'h3,
        EX2DR = 4'h0,
        UPDR  = 4'h5,
        SELIR = 4'h4,
        CAPIR = 4'hE,
        SHIR  = 4'hA,
        EX1IR = 4'h9,
        PSIR  = 4'hB,
        EX2IR = 4'h8,
        UPIR  = 4'hD
    } tap_state_e;

    tap_state_e          state;
    tap_state_e          state_nxt;
    logic [IR_WIDTH-1:0] ir_sr;
    logic [IR_WIDTH-1:0] sel_q;
    logic                tdo_q;
    logic                tdo_en_q;

    // State register; TRST forces Test-Logic-Reset at any time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= TLR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode with tms as the branch bit
    always_comb begin
        state_nxt = state;
        case (state)
            TLR:   state_nxt = tap.tms ? TLR   : RTI;
            RTI:   state_nxt = tap.tms ? SELDR : RTI;
            SELDR: state_nxt = tap.tms ? SELIR : CAPDR;
            CAPDR: state_nxt = tap.tms ? EX1DR : SHDR;
            SHDR:  state_nxt = tap.tms ? EX1DR : SHDR;
            EX1DR: state_nxt = tap.tms ? UPDR  : PSDR;
            PSDR:  state_nxt = tap.tms ? EX2DR : PSDR;
            EX2DR: state_nxt = tap.tms ? UPDR  : SHDR;
            UPDR:  state_nxt = tap.tms ? SELDR : RTI;
            SELIR: state_nxt = tap.tms ? TLR   : CAPIR;
            CAPIR: state_nxt = tap.tms ? EX1IR : SHIR;
            SHIR:  state_nxt = tap.tms ? EX1IR : SHIR;
            EX1IR: state_nxt = tap.tms ? UPIR  : PSIR;
            PSIR:  state_nxt = tap.tms ? EX2IR : PSIR;
            EX2IR: state_nxt = tap.tms ? UPIR  : SHIR;
            UPIR:  state_nxt = tap.tms ? SELDR : RTI;
            default: state_nxt = TLR;
        endcase
    end

    // DR strobes decoded straight from the state register so they are stable all cycle
    always_comb begin
        tap.shift_dr   = 1'b0;
        tap.clk_dr     = 1'b0;
        tap.update_dr  = 1'b0;
        tap.capture_dr = 1'b0;
        case (state)
            CAPDR: begin
                tap.capture_dr = 1'b1;
                tap.clk_dr     = 1'b1;
            end
            SHDR: begin
                tap.shift_dr = 1'b1;
                tap.clk_dr   = 1'b1;
            end
            UPDR:    tap.update_dr = 1'b1;
            default: ;
        endcase
    end

    // Instruction shifter, LSB first towards tdo
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_sr <= '0;
        end else if (state == CAPIR) begin
            ir_sr <= IR_CAPTURE;
        end else if (state == SHIR) begin
            ir_sr <= {tap.tdi, ir_sr[IR_WIDTH-1:1]};
        end
    end

    // Active instruction; reset value is IDCODE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q <= IR_RESET;
        end else if (state == UPIR) begin
            sel_q <= ir_sr;
        end else if (state == TLR) begin
            sel_q <= IR_RESET;
        end
    end

    // Serial out retimed one clk; holds its last bit outside the shift states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_en_q <= (state == SHIR) || (state == SHDR);
            if (state == SHIR) begin
                tdo_q <= ir_sr[0];
            end else if (state == SHDR) begin
                tdo_q <= tap.dr_tdo;
            end
        end
    end

    assign tap.sel    = sel_q;
    assign tap.tdo    = tdo_q;
    assign tap.tdo_en = tdo_en_q;

`ifdef JTAG_TAP_STATE_OUT_EN
    assign tap.tap_state = state;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: directed 1149.1 sequences plus random tms/tdi/dr_tdo/reset
// against a column-based (DR/IR side + step kind) TAP model.
module tb_jtag_tap_ctrl;

    localparam int unsigned IR_WIDTH = 2;
    localparam logic [1:0]  IR_RESET   = 2'b01;
    localparam logic [1:0]  IR_CAPTURE = 2'b01;

    typedef enum int {K_TLR, K_RTI, K_SEL, K_CAP, K_SH, K_EX1, K_PS, K_EX2, K_UP} kind_e;

    typedef struct {
        logic       shift_dr;
        logic       clk_dr;
        logic       update_dr;
        logic       capture_dr;
        logic [1:0] sel;
        logic       tdo;
        logic       tdo_en;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtag_tap_if #(.IR_WIDTH(IR_WIDTH)) tap ();

    jtag_tap_ctrl #(
        .IR_WIDTH  (IR_WIDTH),
        .IR_RESET  (IR_RESET),
        .IR_CAPTURE(IR_CAPTURE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tap(tap.master)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb_q[$];

    // Reference model: state as (kind, side) where side 1 = IR column
    kind_e m_kind;
    bit    m_ir;
    int    m_irsr;
    int    m_sel;
    bit    m_tdo;
    bit    m_tdo_en;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        e.shift_dr   = !m_ir && m_kind == K_SH;
        e.capture_dr = !m_ir && m_kind == K_CAP;
        e.clk_dr     = e.shift_dr || e.capture_dr;
        e.update_dr  = !m_ir && m_kind == K_UP;
        e.sel        = 2'(m_sel);
        e.tdo        = m_tdo;
        e.tdo_en     = m_tdo_en;
        return e;
    endfunction

    task automatic model_reset();
        m_kind = K_TLR; m_ir = 1'b0; m_irsr = 0;
        m_sel = int'(IR_RESET); m_tdo = 1'b0; m_tdo_en = 1'b0;
    endtask

    task automatic model_clock(input bit tms, input bit tdi, input bit dr);
        int irsr_n = m_irsr;
        int sel_n  = m_sel;
        m_tdo_en = (m_kind == K_SH);
        if (m_kind == K_SH) m_tdo = m_ir ? m_irsr[0] : dr;
        if (m_ir && m_kind == K_CAP) irsr_n = int'(IR_CAPTURE);
        if (m_ir && m_kind == K_SH)  irsr_n = (int'(tdi) * (1 << (IR_WIDTH - 1))) + (m_irsr / 2);
        if (m_ir && m_kind == K_UP)  sel_n  = m_irsr;
        if (m_kind == K_TLR)         sel_n  = int'(IR_RESET);
        m_irsr = irsr_n;
        m_sel  = sel_n;
        case (m_kind)
            K_TLR: begin m_kind = tms ? K_TLR : K_RTI; m_ir = 1'b0; end
            K_RTI: if (tms) begin m_kind = K_SEL; m_ir = 1'b0; end
            K_SEL: if (!tms) m_kind = K_CAP;
                   else if (!m_ir) m_ir = 1'b1;
                   else begin m_kind = K_TLR; m_ir = 1'b0; end
            K_CAP, K_SH: m_kind = tms ? K_EX1 : K_SH;
            K_EX1: m_kind = tms ? K_UP  : K_PS;
            K_PS:  m_kind = tms ? K_EX2 : K_PS;
            K_EX2: m_kind = tms ? K_UP  : K_SH;
            K_UP:  begin m_kind = tms ? K_SEL : K_RTI; m_ir = 1'b0; end
            default: m_kind = K_TLR;
        endcase
    endtask

    // One TCK cycle of stimulus; expectation covers outputs after the coming rising edge
    task automatic step(input bit tms, input bit tdi = 1'b0, input bit dr = 1'b0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        tap.tms = tms; tap.tdi = tdi; tap.dr_tdo = dr;
        model_clock(tms, tdi, dr);
        sb_q.push_back(model_expect());
    endtask

    // Asynchronous reset between edges; outputs must clear before any clock edge
    task automatic step_rst();
        @(negedge clk);
        #1;
        rst = 1'b1;
        tap.tms = 1'b0; tap.tdi = 1'b0; tap.dr_tdo = 1'b0;
        #1;
        chk("rst_async_shift_dr", 8'(tap.shift_dr), 8'h0);
        chk("rst_async_clk_dr",   8'(tap.clk_dr),   8'h0);
        chk("rst_async_sel",      8'(tap.sel),      8'(IR_RESET));
        chk("rst_async_tdo",      8'(tap.tdo),      8'h0);
        chk("rst_async_tdo_en",   8'(tap.tdo_en),   8'h0);
        model_reset();
        sb_q.push_back(model_expect());
    endtask

    task automatic tms_seq(input bit [7:0] bits, input int n);
        for (int i = 0; i < n; i++) step(bits[i]);
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("shift_dr",   8'(tap.shift_dr),   8'(e.shift_dr));
                chk("clk_dr",     8'(tap.clk_dr),     8'(e.clk_dr));
                chk("update_dr",  8'(tap.update_dr),  8'(e.update_dr));
                chk("capture_dr", 8'(tap.capture_dr), 8'(e.capture_dr));
                chk("sel",        8'(tap.sel),        8'(e.sel));
                chk("tdo",        8'(tap.tdo),        8'(e.tdo));
                chk("tdo_en",     8'(tap.tdo_en),     8'(e.tdo_en));
            end
        end
    end

    initial begin
        tap.tms = 1'b1; tap.tdi = 1'b0; tap.dr_tdo = 1'b0;
        model_reset();
        step_rst();

        // IR scan: TLR -> SHIR, shift 0,0, update -> sel 00, RTI
        tms_seq(8'b0_0110, 5);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1);
        step(1'b0);

        // DR scan: capture, shift 1,0,1,1, update
        tms_seq(8'b001, 3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1);
        step(1'b0);

        // Pause-DR for 3 clks, resume shifting, then 5x tms=1 out of SHDR
        tms_seq(8'b001, 3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        tms_seq(8'b1_1111, 5);

        // Reset in SHIR after one bit shifted
        tms_seq(8'b0_0110, 5);
        step(1'b0, 1'b1);
        step_rst();
        step(1'b0);

        // Reset mid-DR-shift
        tms_seq(8'b0010, 4);
        step(1'b0, 1'b0, 1'b1);
        step_rst();

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) step_rst();
            else step($urandom_range(0, 99) < 35, 1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        #2;
        if (sb_q.size() > 0) begin
            n_chk++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
